// File: rtl/sarray_mem_responder_if.sv
// Request/response bus between a requester and sarray_mem_responder:
// AR address queue, R data return and fire-and-forget AW writes.
interface sarray_mem_responder_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 256
);
    logic                  sarray_ar_valid_i;
    logic                  sarray_ar_ready_o;
    logic [ADDR_WIDTH-1:0] sarray_ar_addr_i;
    logic                  sarray_r_valid_o;
    logic                  sarray_r_ready_i;
    logic [DATA_WIDTH-1:0] sarray_r_data_o;
    logic                  sarray_aw_valid_i;
    logic                  sarray_aw_ready_o;
    logic [ADDR_WIDTH-1:0] sarray_aw_addr_i;
    logic [DATA_WIDTH-1:0] sarray_aw_data_i;

    modport master (
        output sarray_ar_valid_i, sarray_ar_addr_i, sarray_r_ready_i,
               sarray_aw_valid_i, sarray_aw_addr_i, sarray_aw_data_i,
        input  sarray_ar_ready_o, sarray_r_valid_o, sarray_r_data_o, sarray_aw_ready_o
    );

    modport slave (
        input  sarray_ar_valid_i, sarray_ar_addr_i, sarray_r_ready_i,
               sarray_aw_valid_i, sarray_aw_addr_i, sarray_aw_data_i,
        output sarray_ar_ready_o, sarray_r_valid_o, sarray_r_data_o, sarray_aw_ready_o
    );
endinterface

// File: rtl/sarray_mem_responder.sv
// Word-addressed memory responder: queued in-order reads with a fixed access
// latency, single-beat writes that are always accepted, write-first forwarding.
module sarray_mem_responder #(
    parameter int ADDR_WIDTH    = 64,
    parameter int DATA_WIDTH    = 256,
    parameter int WORD_SHIFT    = 8,
    parameter int IDX_WIDTH     = 8,
    parameter int RD_LATENCY    = 2,
    parameter int AR_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    sarray_mem_responder_if.slave bus,
    output logic                  busy_o
);
    localparam int PTR_W     = (AR_FIFO_DEPTH > 1) ? $clog2(AR_FIFO_DEPTH) : 1;
    localparam int CNT_W     = $clog2(AR_FIFO_DEPTH) + 1;
    localparam int MEM_DEPTH = 1 << IDX_WIDTH;
    localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

    state_t                 state_r, state_nx;
    logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]       count_r;
    logic [IDX_WIDTH-1:0]   fifo_idx [AR_FIFO_DEPTH];
    logic [IDX_WIDTH-1:0]   rd_idx_r;
    logic [3:0]             lat_cnt_r;
    logic [DATA_WIDTH-1:0]  r_data_r;
    logic [DATA_WIDTH-1:0]  mem [MEM_DEPTH];
    logic                   alive_r;

    logic                   fifo_full, fifo_empty, ar_ready, push, pop, capture, aw_hs;
    logic [IDX_WIDTH-1:0]   ar_idx, aw_idx;
    logic                   unused_addr_bits;

    assign ar_idx     = bus.sarray_ar_addr_i[WORD_SHIFT +: IDX_WIDTH];
    assign aw_idx     = bus.sarray_aw_addr_i[WORD_SHIFT +: IDX_WIDTH];
    assign unused_addr_bits = ^{bus.sarray_ar_addr_i, bus.sarray_aw_addr_i};

    // Ready signals come only from flops, so they are low throughout reset.
    assign fifo_full  = (count_r == CNT_W'(AR_FIFO_DEPTH));
    assign fifo_empty = (count_r == '0);
    assign ar_ready   = alive_r & ~fifo_full;
    assign push       = bus.sarray_ar_valid_i & ar_ready;
    assign aw_hs      = bus.sarray_aw_valid_i & alive_r;

    assign bus.sarray_ar_ready_o = ar_ready;
    assign bus.sarray_aw_ready_o = alive_r;
    assign bus.sarray_r_valid_o  = (state_r == RESP);
    assign bus.sarray_r_data_o   = r_data_r;
    assign busy_o                = ~fifo_empty | (state_r != IDLE);

    always_comb begin
        state_nx = state_r;
        pop      = 1'b0;
        capture  = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = READ;
                end
            end
            READ: begin
                if (lat_cnt_r == 4'd0) begin
                    capture  = 1'b1;
                    state_nx = RESP;
                end
            end
            RESP: begin
                // Chain straight into the next queued read to avoid a bubble.
                if (bus.sarray_r_ready_i) begin
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        state_nx = READ;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            count_r   <= '0;
            rd_idx_r  <= '0;
            lat_cnt_r <= '0;
            r_data_r  <= '0;
            alive_r   <= 1'b0;
        end else begin
            state_r <= state_nx;
            alive_r <= 1'b1;
            if (push)
                wr_ptr_r <= (wr_ptr_r == PTR_W'(AR_FIFO_DEPTH - 1)) ? '0 : wr_ptr_r + 1'b1;
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            if (pop) begin
                rd_idx_r  <= fifo_idx[rd_ptr_r];
                rd_ptr_r  <= (rd_ptr_r == PTR_W'(AR_FIFO_DEPTH - 1)) ? '0 : rd_ptr_r + 1'b1;
                lat_cnt_r <= LAT_INIT;
            end else if (state_r == READ && lat_cnt_r != 4'd0) begin
                lat_cnt_r <= lat_cnt_r - 1'b1;
            end
            // A write landing on the captured word this edge wins over the stale array copy.
            if (capture)
                r_data_r <= (aw_hs && aw_idx == rd_idx_r) ? bus.sarray_aw_data_i : mem[rd_idx_r];
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_idx[wr_ptr_r] <= ar_idx;
        if (aw_hs)
            mem[aw_idx] <= bus.sarray_aw_data_i;
    end
endmodule

// File: doc/sarray_mem_responder.md
SARRAY_MEM_RESPONDER -- requirements
Module: sarray_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 256, width of each R beat and AW beat.
REQ-003 SHALL have parameter WORD_SHIFT, default 8, log2 of the byte stride between consecutive beats.
REQ-004 SHALL have parameter IDX_WIDTH, default 8, word index width; memory depth is 2^IDX_WIDTH words.
REQ-005 SHALL have parameter RD_LATENCY, default 2, range 1..15, cycles spent in READ.
REQ-006 SHALL have parameter AR_FIFO_DEPTH, default 4, power of two, AR request queue depth.
REQ-007 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-009 SHALL have port sarray_ar_valid_i, input, 1, read request valid.
REQ-010 SHALL have port sarray_ar_ready_o, output, 1, read request accepted.
REQ-011 SHALL have port sarray_ar_addr_i, input, ADDR_WIDTH, read byte address.
REQ-012 SHALL have port sarray_r_valid_o, output, 1, read data valid.
REQ-013 SHALL have port sarray_r_ready_i, input, 1, requester accepts read data.
REQ-014 SHALL have port sarray_r_data_o, output, DATA_WIDTH, read data.
REQ-015 SHALL have port sarray_aw_valid_i, input, 1, write request valid.
REQ-016 SHALL have port sarray_aw_ready_o, output, 1, write accepted.
REQ-017 SHALL have port sarray_aw_addr_i, input, ADDR_WIDTH, write byte address.
REQ-018 SHALL have port sarray_aw_data_i, input, DATA_WIDTH, write data.
REQ-019 SHALL have port busy_o, output, 1, high when the AR FIFO is non-empty or the FSM is not IDLE.

Function
REQ-020 SHALL compute the word index as addr[WORD_SHIFT +: IDX_WIDTH]; low bits are ignored and higher bits wrap modulo 2^IDX_WIDTH with no error.
REQ-021 SHALL drive ar_ready = ~fifo_full combinationally from registered state only; a push and a pop in the same cycle while full SHALL NOT assert ar_ready.
REQ-022 SHALL push the AR address on ar_valid & ar_ready; the FIFO SHALL be in order with wrap-around pointers and a count register of width log2(AR_FIFO_DEPTH)+1.
REQ-023 SHALL implement FSM states IDLE, READ and RESP, with at most one read outstanding past the FIFO.
REQ-024 In IDLE with the FIFO non-empty, the FSM SHALL pop the head into rd_idx_r, load lat_cnt = RD_LATENCY-1, and enter READ.
REQ-025 In READ, the FSM SHALL decrement lat_cnt; at lat_cnt==0 it SHALL capture data into r_data_r and enter RESP.
REQ-026 In RESP, r_valid_o SHALL be 1 and r_data_o SHALL hold r_data_r stable until r_valid & r_ready.
REQ-027 On the R handshake, the FSM SHALL pop the next entry directly into READ if the FIFO is non-empty, otherwise go to IDLE, with no idle bubble.
REQ-028 Latency: an AR handshake at edge 0, with the FIFO empty and the FSM in IDLE, SHALL produce r_valid_o high after edge RD_LATENCY+1.
REQ-029 SHALL hold aw_ready_o = 1 outside reset; on an aw handshake, mem[aw_idx] SHALL be written at that edge.
REQ-030 On a same-edge write and read capture to the same index, the read SHALL return the AW data (write-first forwarding).
REQ-031 SHALL return R beats in AR acceptance order, one beat per AR.
REQ-032 Width: all counters SHALL saturate neither up nor down, and the FSM SHALL never pop an empty FIFO or push a full one.

Reset
REQ-033 While rst is high: FIFO pointers and count = 0, FSM = IDLE, lat_cnt = 0, r_valid_o = 0, busy_o = 0, aw_ready_o = 0, ar_ready_o = 0.
REQ-034 Reset SHALL clear r_data_o to 0; memory contents are not reset.
REQ-035 Reset asserted mid-READ or mid-RESP SHALL discard the queued and in-flight reads, and no r_valid_o SHALL follow deassertion.

Verification
REQ-036 Write 0xA5..A5 at addr 0x300, then AR at 0x300 with r_ready=1 and RD_LATENCY=2 -> r_valid high exactly 3 cycles after the AR handshake, data 0xA5..A5.
REQ-037 Six back-to-back ARs to 0x000, 0x100 .. 0x500 with r_ready=0 -> ar_ready low after 4 accepted plus 1 in flight; release r_ready -> 6 beats returned in order, data held stable while stalled.
REQ-038 Write to 0x10000 with IDX_WIDTH=8, then read 0x0 -> returns the written data (wrap-around).
REQ-039 AW to index 5 on the same edge a READ captures index 5 -> R data equals the new AW data; a different index returns the old data.
REQ-040 Assert rst during RESP with 2 entries queued -> r_valid 0 and busy 0 immediately; after release, no beats until a new AR arrives.
